// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers.
package pipe_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h1000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Payload bundle widths for the four inter-stage registers
  localparam int unsigned IF_ID_W  = 32'd48;
  localparam int unsigned ID_EX_W  = 32'd96;
  localparam int unsigned EX_MEM_W = 32'd72;
  localparam int unsigned MEM_WB_W = 32'd40;

  function automatic logic [1:0] occ_of(input stage_state_e st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Handshake FSM for the elastic stage: tracks occupancy and steers the main/skid
// register loads.
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter bit SKID = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       in_valid_i,
  input  logic       out_ready_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [1:0] occupancy_o,
  output logic       load_main_o,
  output logic       load_skid_o,
  output logic       main_from_skid_o
);

  stage_state_e state_q, state_d;
  logic         in_ready_q;
  logic         in_fire_s, out_fire_s;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign occupancy_o = occ_of(state_q);
  assign in_fire_s   = in_valid_i & in_ready_o;
  assign out_fire_s  = out_valid_o & out_ready_i;

  // Without a skid entry the stage may only accept while the head is leaving
  always_comb begin
    if (SKID) begin
      in_ready_o = in_ready_q;
    end else begin
      in_ready_o = ~out_valid_o | out_ready_i;
    end
  end

  // Next state and register-load steering
  always_comb begin
    state_d          = state_q;
    load_main_o      = 1'b0;
    load_skid_o      = 1'b0;
    main_from_skid_o = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d     = ST_ONE;
            load_main_o = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_d     = ST_ONE;
            load_main_o = 1'b1;
          end else if (out_fire_s) begin
            state_d = ST_EMPTY;
          end else if (in_fire_s && SKID) begin
            state_d     = ST_TWO;
            load_skid_o = 1'b1;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_fire_s) begin
            state_d          = ST_ONE;
            load_main_o      = 1'b1;
            main_from_skid_o = 1'b1;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State register; in_ready is registered so out_ready never reaches it combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Valid/ready elastic pipeline stage with optional 2-entry skid buffer and flush.
// Drives BUBBLE on out_data whenever no payload is held.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32'd16,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(NOP_INSTR),
  parameter bit               SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             load_main_s, load_skid_s, main_from_skid_s;

  pipe_stage_ctrl #(.SKID(SKID)) u_ctrl (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush),
    .in_valid_i       (in_valid),
    .out_ready_i      (out_ready),
    .in_ready_o       (in_ready),
    .out_valid_o      (out_valid),
    .occupancy_o      (occupancy),
    .load_main_o      (load_main_s),
    .load_skid_o      (load_skid_s),
    .main_from_skid_o (main_from_skid_s)
  );

  // Payload register next values; main refills from skid to preserve FIFO order
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (load_main_s) begin
      if (main_from_skid_s) begin
        main_d = skid_q;
      end else begin
        main_d = in_data;
      end
    end else begin
      main_d = main_q;
    end
    if (load_skid_s) begin
      skid_d = in_data;
    end else begin
      skid_d = skid_q;
    end
  end

  // Payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= {WIDTH{1'b0}};
      skid_q <= {WIDTH{1'b0}};
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Head payload or bubble
  always_comb begin
    if (out_valid) begin
      out_data = main_q;
    end else begin
      out_data = BUBBLE;
    end
  end

endmodule
